// File: rtl/min_max_scheduler.sv
// Round-robin scheduler sharing one min/max engine among four requesters.
// Optional job watchdog enabled by defining MMS_WATCHDOG_EN.
module min_max_scheduler #(
  parameter int TMO_LIMIT = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] ack,
  output logic [1:0] sel,
  output logic       eng_start,
  input  logic       eng_done,
  input  logic [7:0] eng_max,
  input  logic [7:0] eng_min,
  output logic [7:0] res_max,
  output logic [7:0] res_min,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    WAIT  = 4'b0100,
    ACK   = 4'b1000
  } state_t;

  state_t     state, state_next;
  logic [1:0] ptr, ptr_next;
  logic [1:0] sel_next;
  logic [7:0] res_max_next, res_min_next;
  logic [1:0] winner;
  logic       found;

  // Parameter only matters with the watchdog; out-of-range values leave a marker block.
  if (TMO_LIMIT < 1 || TMO_LIMIT > 63) begin : g_tmo_limit_out_of_range
  end

`ifdef MMS_WATCHDOG_EN
  logic [5:0] wd_cnt, wd_cnt_next;
  logic       err_flag, err_flag_next;
  logic       timeout;
  assign timeout = ((wd_cnt + 6'd1) == 6'(TMO_LIMIT));
`endif

  // Circular search starting just after the last served requester.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      sel      <= 2'd0;
      res_max  <= 8'h00;
      res_min  <= 8'h00;
`ifdef MMS_WATCHDOG_EN
      wd_cnt   <= 6'd0;
      err_flag <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      sel      <= sel_next;
      res_max  <= res_max_next;
      res_min  <= res_min_next;
`ifdef MMS_WATCHDOG_EN
      wd_cnt   <= wd_cnt_next;
      err_flag <= err_flag_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    sel_next      = sel;
    res_max_next  = res_max;
    res_min_next  = res_min;
`ifdef MMS_WATCHDOG_EN
    wd_cnt_next   = wd_cnt;
    err_flag_next = err_flag;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          sel_next   = winner;
          state_next = START;
        end
      end
      START: begin
`ifdef MMS_WATCHDOG_EN
        wd_cnt_next = 6'd0;
`endif
        state_next = WAIT;
      end
      WAIT: begin
`ifdef MMS_WATCHDOG_EN
        wd_cnt_next = wd_cnt + 6'd1;
`endif
        if (eng_done) begin
          res_max_next = eng_max;
          res_min_next = eng_min;
`ifdef MMS_WATCHDOG_EN
          err_flag_next = 1'b0;
`endif
          state_next = ACK;
        end
`ifdef MMS_WATCHDOG_EN
        // A done arriving on the limit cycle wins over the abort.
        else if (timeout) begin
          res_max_next  = 8'h00;
          res_min_next  = 8'hFF;
          err_flag_next = 1'b1;
          state_next    = ACK;
        end
`endif
      end
      ACK: begin
        ptr_next   = sel;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt       = (state != IDLE) ? (4'b0001 << sel) : 4'b0000;
  assign ack       = (state == ACK)  ? (4'b0001 << sel) : 4'b0000;
  assign eng_start = (state == START);
`ifdef MMS_WATCHDOG_EN
  assign err       = err_flag && (state == ACK);
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_min_max_scheduler.sv
// Directed bench for min_max_scheduler with a queue-based result scoreboard.
module tb_min_max_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, gnt, ack;
  logic [1:0] sel;
  logic       eng_start, eng_done;
  logic [7:0] eng_max, eng_min, res_max, res_min;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] mx;
    logic [7:0] mn;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  min_max_scheduler #(.TMO_LIMIT(20)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .ack(ack), .sel(sel),
    .eng_start(eng_start), .eng_done(eng_done), .eng_max(eng_max), .eng_min(eng_min),
    .res_max(res_max), .res_min(res_min), .err(err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // One job: request, wait for start, run engine for dly WAIT cycles, check the ack.
  task automatic do_job(input logic [3:0] r, input logic [3:0] mid_r, input logic [1:0] exp_sel,
                        input int dly, input bit give_done, input logic [7:0] mx, input logic [7:0] mn);
    exp_t e;
    bit   seen;
    bit   bad;
    req = r;
    e.sel = exp_sel;
    if (give_done) begin
      e.mx = mx; e.mn = mn; e.err = 1'b0;
    end else begin
      e.mx = 8'h00; e.mn = 8'hFF; e.err = 1'b1;
    end
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = eng_start;
    end
    chk("start_seen", 16'(seen), 16'd1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    chk("gnt_start", 16'(gnt), 16'(4'b0001 << exp_sel));
    chk("sel_start", 16'(sel), 16'(exp_sel));
    req = mid_r;
    bad = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (!$onehot(gnt) || gnt !== (4'b0001 << exp_sel) || sel !== exp_sel ||
          eng_start !== 1'b0 || ack !== 4'b0000)
        bad = 1'b1;
    end
    chk("wait_stable", 16'(bad), 16'd0);
    eng_done = give_done; eng_max = mx; eng_min = mn;
    @(negedge clk);
    eng_done = 1'b0; eng_max = 8'h5A; eng_min = 8'hA5;
    e = sb.pop_front();
    chk("ack", 16'(ack), 16'(4'b0001 << e.sel));
    chk("gnt_ack", 16'(gnt), 16'(4'b0001 << e.sel));
    chk("res_max", 16'(res_max), 16'(e.mx));
    chk("res_min", 16'(res_min), 16'(e.mn));
    chk("err", 16'(err), 16'(e.err));
    $display("job sel=%0d ack=%b res_max=%h res_min=%h err=%b", sel, ack, res_max, res_min, err);
    @(negedge clk);
    chk("ack_pulse", 16'(ack), 16'd0);
    chk("gnt_idle", 16'(gnt), 16'd0);
  endtask

  initial begin
    bit seen;
    bit bad;
    reset = 1'b1; req = 4'b0000; eng_done = 1'b0; eng_max = 8'h00; eng_min = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_sel", 16'(sel), 16'd0);
    chk("rst_start", 16'(eng_start), 16'd0);
    chk("rst_res", {res_max, res_min}, 16'h0000);
    chk("rst_err", 16'(err), 16'd0);
    reset = 1'b0;

    // Single requester, engine done after 18 cycles.
    do_job(4'b0001, 4'b0001, 2'd0, 18, 1'b1, 8'hF0, 8'h03);
    req = 4'b0000;

    // All requesters held: order 0,1,2,3,0.
    do_reset();
    for (int j = 0; j < 5; j++)
      do_job(4'b1111, 4'b1111, 2'(j), 3, 1'b1, 8'h10 + 8'(j), 8'h01 + 8'(j));
    req = 4'b0000;

    // Requester 1 arrives while 2 is in service.
    do_reset();
    do_job(4'b0100, 4'b0110, 2'd2, 5, 1'b1, 8'h77, 8'h11);
    do_job(4'b0110, 4'b0110, 2'd1, 4, 1'b1, 8'h88, 8'h22);
    req = 4'b0000;

    // Reset during WAIT of requester 3 abandons the job.
    @(negedge clk);
    req = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = eng_start;
    end
    chk("r3_start_seen", 16'(seen), 16'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 16'(gnt), 16'd0);
    chk("mid_rst_ack", 16'(ack), 16'd0);
    chk("mid_rst_sel", 16'(sel), 16'd0);
    chk("mid_rst_res", {res_max, res_min}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    do_job(4'b1000, 4'b1000, 2'd3, 6, 1'b1, 8'h9C, 8'h05);
    req = 4'b0000;

    // Done held in IDLE with no requests is ignored.
    do_reset();
    eng_done = 1'b1; eng_max = 8'hEE; eng_min = 8'h44;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 || ack !== 4'b0000 || eng_start !== 1'b0) bad = 1'b1;
    end
    chk("idle_done_ignored", 16'(bad), 16'd0);
    chk("idle_res_hold", {res_max, res_min}, 16'h0000);
    eng_done = 1'b0;

`ifdef MMS_WATCHDOG_EN
    // Watchdog abort after 20 WAIT cycles, then done exactly on cycle 20.
    do_reset();
    do_job(4'b0010, 4'b0010, 2'd1, 20, 1'b0, 8'h00, 8'h00);
    do_job(4'b0010, 4'b0010, 2'd1, 20, 1'b1, 8'hC3, 8'h3C);
    req = 4'b0000;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
